// File: rtl/mem_bist_ctrl_if.sv
// Memory-side bus of the BIST engine: strobes, address and data to and from
// the synchronous memory under test.
interface mem_bist_ctrl_if #(
    parameter int ADDR_W = 5
);
    // No valid/ready pair on this bus: read or write high qualifies addr (and
    // data_in for writes) in that cycle; data_out is valid READ_LAT cycles
    // after a read and is consumed unconditionally (no back-pressure).
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_in;
    logic [7:0]        data_out;

    modport master (output read, write, addr, data_in, input data_out);
    modport slave  (input read, write, addr, data_in, output data_out);
endinterface

// File: rtl/mem_bist_ctrl.sv
// Memory BIST engine: write a pattern to every address, read it back, compare.
// Optional MEM_BIST_INVERSE_PASS_EN adds a second pass with the inverted pattern.
module mem_bist_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          pattern_sel,
    mem_bist_ctrl_if.master     bus,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W+1:0]   err_count,
    output logic [ADDR_W-1:0]   first_fail_addr,
    output logic [2:0]          dbg_state
);
    localparam int                DW        = $clog2(READ_LAT + 1) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((1 << ADDR_W) - 1);
    localparam logic [7:0]        SEED      = 8'hA5;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [1:0]        sel_q;
    logic              inv_q;
    logic [7:0]        lfsr;
    logic [DW-1:0]     drain_cnt;
    logic              pipe_v    [READ_LAT];
    logic [7:0]        pipe_exp  [READ_LAT];
    logic [ADDR_W-1:0] pipe_addr [READ_LAT];

    logic [7:0]        cur_exp;
    logic [7:0]        next_lfsr;
    logic [ADDR_W-1:0] next_addr;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [7:0] pattern(input logic [1:0] sel, input logic [ADDR_W-1:0] a,
                                           input logic [7:0] l, input logic inv);
        logic [7:0] p;
        case (sel)
            2'd0:    p = 8'h00;
            2'd1:    p = 8'(a);
            2'd2:    p = a[0] ? 8'hAA : 8'h55;
            default: p = l;
        endcase
        return inv ? ~p : p;
    endfunction

    // lfsr always tracks the value belonging to the address currently on the bus
    assign cur_exp   = pattern(sel_q, bus.addr, lfsr, inv_q);
    assign next_lfsr = lfsr_step(lfsr);
    assign next_addr = bus.addr + 1'b1;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            sel_q           <= 2'd0;
            inv_q           <= 1'b0;
            lfsr            <= 8'h00;
            drain_cnt       <= '0;
            bus.read        <= 1'b0;
            bus.write       <= 1'b0;
            bus.addr        <= '0;
            bus.data_in     <= 8'h00;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_v[i]    <= 1'b0;
                pipe_exp[i]  <= 8'h00;
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_v[0]    <= bus.read;
            pipe_exp[0]  <= cur_exp;
            pipe_addr[0] <= bus.addr;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end

            // err_count still zero means this is the first mismatch of the run
            if (pipe_v[READ_LAT-1] && bus.data_out != pipe_exp[READ_LAT-1]) begin
                if (err_count != '1)
                    err_count <= err_count + 1'b1;
                if (err_count == '0)
                    first_fail_addr <= pipe_addr[READ_LAT-1];
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state           <= S_WRITE;
                        sel_q           <= pattern_sel;
                        inv_q           <= 1'b0;
                        lfsr            <= SEED;
                        bus.write       <= 1'b1;
                        bus.addr        <= '0;
                        bus.data_in     <= pattern(pattern_sel, '0, SEED, 1'b0);
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_fail_addr <= '0;
                    end
                end
                S_WRITE: begin
                    if (bus.addr == LAST_ADDR) begin
                        state       <= S_READ;
                        bus.write   <= 1'b0;
                        bus.read    <= 1'b1;
                        bus.addr    <= '0;
                        bus.data_in <= 8'h00;
                        lfsr        <= SEED;
                    end else begin
                        bus.addr    <= next_addr;
                        lfsr        <= next_lfsr;
                        bus.data_in <= pattern(sel_q, next_addr, next_lfsr, inv_q);
                    end
                end
                S_READ: begin
                    if (bus.addr == LAST_ADDR) begin
                        state     <= S_DRAIN;
                        bus.read  <= 1'b0;
                        bus.addr  <= '0;
                        drain_cnt <= '0;
                    end else begin
                        bus.addr <= next_addr;
                        lfsr     <= next_lfsr;
                    end
                end
                S_DRAIN: begin
`ifdef MEM_BIST_INVERSE_PASS_EN
                    // The inverse pass may start while the last compare is still in flight
                    if (!inv_q && drain_cnt == DW'(READ_LAT - 1)) begin
                        state       <= S_WRITE;
                        inv_q       <= 1'b1;
                        lfsr        <= SEED;
                        bus.write   <= 1'b1;
                        bus.addr    <= '0;
                        bus.data_in <= pattern(sel_q, '0, SEED, 1'b1);
                    end else if (drain_cnt == DW'(READ_LAT)) begin
`else
                    if (drain_cnt == DW'(READ_LAT)) begin
`endif
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: behavioural 32x8 memory with injectable faults,
// write-data and result scoreboards fed by directed test runs.
module tb_mem_bist_ctrl;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
`ifdef MEM_BIST_INVERSE_PASS_EN
    localparam bit INV = 1'b1;
    localparam int LAT = 131;
`else
    localparam bit INV = 1'b0;
    localparam int LAT = 66;
`endif

    typedef struct {
        int err;
        int ffa;
        int pass;
        int lat;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        pattern_sel = 2'd0;
    logic              busy, done, pass;
    logic [ADDR_W+1:0] err_count;
    logic [ADDR_W-1:0] first_fail_addr;
    logic [2:0]        dbg_state;

    mem_bist_ctrl_if #(.ADDR_W(ADDR_W)) mbus ();

    mem_bist_ctrl #(.ADDR_W(ADDR_W), .READ_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern_sel(pattern_sel),
        .bus(mbus.master), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_addr(first_fail_addr), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model with fault injection
    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_q = 8'h00;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_data;
    bit                alias_fault = 1'b0;
    bit                stuck_all = 1'b0;
    int                stuck_addr = -1;

    initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        m_addr = mbus.addr;
        if (alias_fault) m_addr[0] = 1'b1;
        if (mbus.write) begin
            m_data = mbus.data_in;
            if (stuck_all || int'(m_addr) == stuck_addr) m_data[3] = 1'b0;
            mem[m_addr] <= m_data;
        end
        if (mbus.read) rd_q <= mem[m_addr];
    end
    assign mbus.data_out = rd_q;

    // scoreboard state
    int          checks = 0;
    int          failures = 0;
    logic [12:0] exp_q[$];
    res_t        res_q[$];
    logic        done_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_model(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic push_writes(input logic [1:0] sel, input bit inv);
        logic [7:0] l;
        logic [7:0] p;
        logic [4:0] a;
        l = 8'hA5;
        for (int i = 0; i < DEPTH; i++) begin
            a = 5'(i);
            case (sel)
                2'd0:    p = 8'h00;
                2'd1:    p = {3'b000, a};
                2'd2:    p = a[0] ? 8'hAA : 8'h55;
                default: p = l;
            endcase
            if (inv) p = ~p;
            exp_q.push_back({a, p});
            l = lfsr_model(l);
        end
    endtask

    // monitor: write bus against expected pattern, and strobe exclusivity
    always @(negedge clk) begin
        if (rst_n && busy)
            check("rd_wr_excl", {31'd0, mbus.read & mbus.write}, 32'd0);
        if (rst_n && mbus.write) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mbus.addr), 32'(e[12:8]));
                check("wr_data", 32'(mbus.data_in), 32'(e[7:0]));
            end
        end
    end

    // monitor: result on rising done
    always @(negedge clk) begin
        if (rst_n && done && !done_q) begin
            if (res_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                res_t r;
                r = res_q.pop_front();
                check("err_count", 32'(err_count), 32'(r.err));
                check("first_fail_addr", 32'(first_fail_addr), 32'(r.ffa));
                check("pass", 32'(pass), 32'(r.pass));
                check("done_latency", 32'(cyc - start_cyc), 32'(r.lat));
                check("idle_bus", {15'd0, mbus.read, mbus.write, mbus.addr, mbus.data_in, busy},
                      32'd0);
            end
        end
        done_q = done;
    end

    // driver tasks
    task automatic run_test(input logic [1:0] sel, input int err, input int ffa, input int p);
        res_t r;
        push_writes(sel, 1'b0);
        if (INV) push_writes(sel, 1'b1);
        r.err = err; r.ffa = ffa; r.pass = p; r.lat = LAT;
        res_q.push_back(r);
        @(negedge clk);
        start = 1'b1;
        pattern_sel = sel;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && !done; i++) @(negedge clk);
        if (!done) check("done_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_write_addr(input int a);
        for (int i = 0; i < 100 && !(mbus.write && int'(mbus.addr) == a); i++) @(negedge clk);
        if (!(mbus.write && int'(mbus.addr) == a)) check("write_addr_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] all_outputs();
        return {2'd0, mbus.read, mbus.write, mbus.addr, mbus.data_in, busy, done, pass,
                err_count, first_fail_addr};
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ideal memory, all zeros
        run_test(2'd0, 0, 0, 1);
        wait_done();

        // bit 3 stuck-at-0 at address 12
        stuck_addr = 12;
        run_test(2'd1, 1, 12, 0);
        wait_done();
        run_test(2'd0, INV ? 1 : 0, INV ? 12 : 0, INV ? 0 : 1);
        wait_done();
        stuck_addr = -1;

        // address bit 0 stuck-at-1
        alias_fault = 1'b1;
        run_test(2'd2, INV ? 32 : 16, 0, 0);
        wait_done();
        alias_fault = 1'b0;

        // LFSR sequence on ideal memory
        run_test(2'd3, 0, 0, 1);
        wait_done();

        // start re-pulsed mid-write is ignored
        run_test(2'd1, 0, 0, 1);
        wait_write_addr(5);
        start = 1'b1;
        pattern_sel = 2'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // asynchronous abort during write phase, then a clean rerun
        run_test(2'd1, 0, 0, 1);
        wait_write_addr(10);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_abort", all_outputs(), 32'd0);
        exp_q.delete();
        res_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_test(2'd2, 0, 0, 1);
        wait_done();

        // bit 3 stuck-at-0 everywhere
        stuck_all = 1'b1;
        run_test(2'd0, INV ? 32 : 0, 0, INV ? 0 : 1);
        wait_done();
        stuck_all = 1'b0;

        check("write_queue_drained", 32'(exp_q.size()), 32'd0);
        check("result_queue_drained", 32'(res_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
Hardware built-in self-test engine that sits directly upstream of the 32x8 synchronous memory and drives its read/write/addr/data_in bus. On start it writes a selected pattern to every address, reads every address back, and compares the returned data against a regenerated expected value. It then reports pass/fail, an error count and the first failing address, which replaces the software write/read/check loop with synthesizable logic.

Parameters:
ADDR_W, 5, address width; DEPTH = 2**ADDR_W locations
READ_LAT, 1, cycles from read asserted to valid data_out (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins test when idle or done
pattern_sel  input  2  0 all-zeros, 1 data=address (zero-extended), 2 checkerboard (even 0x55, odd 0xAA), 3 LFSR
read  output  1  memory read strobe
write  output  1  memory write strobe
addr  output  ADDR_W  memory address
data_in  output  8  write data to memory
data_out  input  8  read data from memory
busy  output  1  test in progress
done  output  1  level; test complete, held until next start
pass  output  1  valid when done; 1 = err_count zero
err_count  output  ADDR_W+2  mismatching reads, saturating
first_fail_addr  output  ADDR_W  address of first mismatch; 0 if none

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset value of every output is 0. The FSM goes to IDLE. Reset asserted mid-test aborts immediately, without waiting for a clock edge.
- FSM states: IDLE -> WRITE -> READ -> DRAIN -> DONE. DONE -> WRITE on start.
- start is sampled only in IDLE or DONE. It is ignored while busy.
- pattern_sel is latched on start.
- Start edge: clear err_count, first_fail_addr, done and pass; set busy.
- WRITE:
  - write=1, read=0.
  - addr counts 0..DEPTH-1, one per cycle, for DEPTH cycles.
  - data_in = pattern(addr).
- READ:
  - read=1, write=0.
  - addr counts 0..DEPTH-1, one per cycle.
  - Expected data and address are delayed through a READ_LAT-deep shift register alongside a valid bit.
- Compare: data_out is compared exactly READ_LAT cycles after each read cycle.
  - On mismatch, increment err_count, saturating at all-ones.
  - On the first mismatch, capture first_fail_addr.
- DRAIN: read=0, write=0 for READ_LAT cycles, until the last compare completes.
- DONE: busy=0, done=1, pass=(err_count==0). read, write, addr and data_in are all 0.
- Latency: done first high 2*DEPTH+READ_LAT+1 cycles after the start edge, i.e. 66 for the default parameters.
- LFSR pattern:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
  - Seed 0xA5 at the start of each write phase and again at the start of each read phase, so both phases see an identical sequence.
  - Advances once per address.
- read and write are never high in the same cycle.
- addr wraps only by the phase change, never mid-phase.

Optional Feature:
MEM_BIST_INVERSE_PASS_EN:
- Defined: after DRAIN, run a second WRITE/READ/DRAIN using the bitwise inverse of the same pattern, with the LFSR reseeded. Errors accumulate into the same err_count. done is asserted at 4*DEPTH+2*READ_LAT+1 = 131 cycles.
- Undefined: single pass only, with the 66-cycle latency above.

Test Plan:
1. Ideal memory, pattern_sel=0, start pulse -> 32 writes of 0x00, 32 reads; done at cycle 66; pass=1, err_count=0, first_fail_addr=0.
2. Memory bit 3 stuck-at-0 at address 12, pattern_sel=1 -> err_count=1, first_fail_addr=12, pass=0. Same fault with pattern_sel=0 -> pass=1.
3. Address bit 0 stuck-at-1 (even aliases odd), pattern_sel=2 -> every even read returns 0xAA; err_count=16, first_fail_addr=0.
4. Ideal memory, pattern_sel=3 -> data_in at addr 0 = 0xA5, addr 1 = bench-computed next LFSR value, whole sequence matches model; pass=1.
5. start re-pulsed during the write phase -> ignored, done still at cycle 66. rst_n low at write cycle 10 -> all outputs 0 asynchronously. After release, a new start runs a full 66-cycle test.
6. With MEM_BIST_INVERSE_PASS_EN, bit 3 stuck-at-0 at all addresses, pattern_sel=0 -> inverse pass reads 0xF7 for expected 0xFF; err_count=32, first_fail_addr=0, done at cycle 131.
